// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core datapath.
//   DATA_W / REG_AW : datapath and register-file address widths
//   load_type_e     : sub-word load encodings carried down the pipe
//   m2r_e           : writeback result-mux select encodings
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LBU = 3'b001,
    LT_LB  = 3'b010,
    LT_LHU = 3'b011,
    LT_LH  = 3'b100
  } load_type_e;

  typedef enum logic [1:0] {
    M2R_ALU = 2'b00,
    M2R_DM  = 2'b01,
    M2R_PC4 = 2'b10
  } m2r_e;

endpackage

// File: rtl/load_ext.sv
// Combinational load aligner / extender.
// Selects the addressed byte or halfword of a little-endian memory word
// and zero- or sign-extends it to the datapath width.
//   rd        : raw word read from data memory
//   off       : low two address bits (byte offset within the word)
//   load_type : load encoding; unknown encodings behave as a full word
//   dm_out    : aligned, extended load data
module load_ext (
  input  logic [31:0] rd,
  input  logic [1:0]  off,
  input  logic [2:0]  load_type,
  output logic [31:0] dm_out
);
  import mips_pkg::*;

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    logic signed [7:0]  sb;
    logic signed [31:0] sw;
    sb = b;
    sw = sb;
    return sgn ? sw : {24'b0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    logic signed [15:0] sh;
    logic signed [31:0] sw;
    sh = h;
    sw = sh;
    return sgn ? sw : {16'b0, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd[7:0];
    case (off)
      2'd1:    byte_sel = rd[15:8];
      2'd2:    byte_sel = rd[23:16];
      2'd3:    byte_sel = rd[31:24];
      default: byte_sel = rd[7:0];
    endcase
    // Halfword select ignores off[0]; a misaligned halfword is only flagged.
    half_sel = off[1] ? rd[31:16] : rd[15:0];
  end

  always_comb begin
    dm_out = rd;
    case (load_type)
      LT_LBU:  dm_out = ext8(byte_sel, 1'b0);
      LT_LB:   dm_out = ext8(byte_sel, 1'b1);
      LT_LHU:  dm_out = ext16(half_sel, 1'b0);
      LT_LH:   dm_out = ext16(half_sel, 1'b1);
      default: dm_out = rd;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register of the 5-stage MIPS core.
// Latches the M-stage results and writeback control, then aligns/extends
// sub-word loads combinationally on the W side for the result mux.
//   clk, reset_n     : rising-edge clock, asynchronous active-low reset
//   en, clr          : latch enable (0 = stall) and bubble insert (flush)
//   *_M inputs       : M-stage instruction slot
//   *_W outputs      : registered / W-side values for the result mux
//   AdEL_W           : misaligned-load flag (informational)
//   retired          : count of valid instructions that entered W
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              clr,
  input  logic              valid_M,
  input  logic [DATA_W-1:0] ALUOut_M,
  input  logic [DATA_W-1:0] RD_M,
  input  logic [DATA_W-1:0] PC4_M,
  input  logic [REG_AW-1:0] WriteReg_M,
  input  logic              RegWrite_M,
  input  logic [1:0]        MemtoReg_M,
  input  logic [2:0]        LoadType_M,
  output logic [DATA_W-1:0] ALUOut_W,
  output logic [DATA_W-1:0] DMOut_W,
  output logic [DATA_W-1:0] PC4_W,
  output logic [REG_AW-1:0] WriteReg_W,
  output logic              RegWrite_W,
  output logic [1:0]        MemtoReg_W,
  output logic              valid_W,
  output logic              AdEL_W,
  output logic [CNT_W-1:0]  retired
);
  import mips_pkg::*;

  logic [DATA_W-1:0] alu_p1;
  logic [DATA_W-1:0] rd_p1;
  logic [DATA_W-1:0] pc4_p1;
  logic [REG_AW-1:0] wr_p1;
  logic              rw_p1;
  logic [1:0]        m2r_p1;
  logic [2:0]        lt_p1;
  logic              vld_p1;
  logic [CNT_W-1:0]  retired_p1;

  // M -> W stage boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_p1     <= '0;
      rd_p1      <= '0;
      pc4_p1     <= '0;
      wr_p1      <= '0;
      rw_p1      <= 1'b0;
      m2r_p1     <= 2'b00;
      lt_p1      <= 3'b000;
      vld_p1     <= 1'b0;
      retired_p1 <= '0;
    end else if (clr) begin
      alu_p1 <= '0;
      rd_p1  <= '0;
      pc4_p1 <= '0;
      wr_p1  <= '0;
      rw_p1  <= 1'b0;
      m2r_p1 <= 2'b00;
      lt_p1  <= 3'b000;
      vld_p1 <= 1'b0;
    end else if (en) begin
      alu_p1 <= ALUOut_M;
      rd_p1  <= RD_M;
      pc4_p1 <= PC4_M;
      wr_p1  <= WriteReg_M;
      rw_p1  <= RegWrite_M;
      m2r_p1 <= MemtoReg_M;
      lt_p1  <= LoadType_M;
      vld_p1 <= valid_M;
      if (valid_M) begin
        retired_p1 <= retired_p1 + CNT_W'(1);
      end
    end
  end

  logic [1:0] off;
  logic       is_half;
  logic       is_word;

  assign off     = alu_p1[1:0];
  assign is_half = (lt_p1 == LT_LH) || (lt_p1 == LT_LHU);
  // Anything that is not a byte or halfword load is treated as a full word.
  assign is_word = !is_half && (lt_p1 != LT_LB) && (lt_p1 != LT_LBU);

  load_ext u_load_ext (
    .rd        (rd_p1),
    .off       (off),
    .load_type (lt_p1),
    .dm_out    (DMOut_W)
  );

  assign ALUOut_W   = alu_p1;
  assign PC4_W      = pc4_p1;
  assign WriteReg_W = wr_p1;
  assign MemtoReg_W = m2r_p1;
  assign valid_W    = vld_p1;
  assign retired    = retired_p1;
  // $0 is hard-wired zero, so a write to it is never presented.
  assign RegWrite_W = rw_p1 && vld_p1 && (wr_p1 != '0);
  assign AdEL_W     = vld_p1 && (m2r_p1 == M2R_DM) &&
                      ((is_word && (off != 2'b00)) || (is_half && off[0]));

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en, clr, valid_M;
  logic [31:0] ALUOut_M, RD_M, PC4_M;
  logic [4:0]  WriteReg_M;
  logic        RegWrite_M;
  logic [1:0]  MemtoReg_M;
  logic [2:0]  LoadType_M;
  logic [31:0] ALUOut_W, DMOut_W, PC4_W;
  logic [4:0]  WriteReg_W;
  logic        RegWrite_W;
  logic [1:0]  MemtoReg_W;
  logic        valid_W, AdEL_W;
  logic [3:0]  retired;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mem_wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .valid_M(valid_M),
    .ALUOut_M(ALUOut_M), .RD_M(RD_M), .PC4_M(PC4_M), .WriteReg_M(WriteReg_M),
    .RegWrite_M(RegWrite_M), .MemtoReg_M(MemtoReg_M), .LoadType_M(LoadType_M),
    .ALUOut_W(ALUOut_W), .DMOut_W(DMOut_W), .PC4_W(PC4_W), .WriteReg_W(WriteReg_W),
    .RegWrite_W(RegWrite_W), .MemtoReg_W(MemtoReg_W), .valid_W(valid_W),
    .AdEL_W(AdEL_W), .retired(retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] alu, dm, pc4;
    logic [4:0]  wr;
    logic        rw;
    logic [1:0]  m2r;
    logic        vld, adel;
    logic [3:0]  ret;
  } exp_t;

  exp_t q[$];
  exp_t last;
  exp_t mx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ALUOut_W"}, ALUOut_W, 32'h0);
    chk({tag, " DMOut_W"}, DMOut_W, 32'h0);
    chk({tag, " PC4_W"}, PC4_W, 32'h0);
    chk({tag, " WriteReg_W"}, 32'(WriteReg_W), 32'h0);
    chk({tag, " RegWrite_W"}, 32'(RegWrite_W), 32'h0);
    chk({tag, " MemtoReg_W"}, 32'(MemtoReg_W), 32'h0);
    chk({tag, " valid_W"}, 32'(valid_W), 32'h0);
    chk({tag, " AdEL_W"}, 32'(AdEL_W), 32'h0);
    chk({tag, " retired"}, 32'(retired), 32'h0);
  endtask

  // Drive one cycle of M-stage stimulus and queue the W-side response
  // expected after the next rising edge. xdm/xadel are hand-computed.
  task automatic issue(input logic e, input logic c, input logic v,
                       input logic [31:0] alu, input logic [31:0] rd,
                       input logic [31:0] pc, input logic [4:0] w,
                       input logic r, input logic [1:0] m, input logic [2:0] lt,
                       input logic [31:0] xdm, input logic xadel);
    exp_t x;
    @(posedge clk); #1;
    en = e; clr = c; valid_M = v; ALUOut_M = alu; RD_M = rd; PC4_M = pc;
    WriteReg_M = w; RegWrite_M = r; MemtoReg_M = m; LoadType_M = lt;
    if (c) begin
      x = '{default: 0};
      x.ret = last.ret;
    end else if (e) begin
      x.alu = alu; x.dm = xdm; x.pc4 = pc; x.wr = w;
      x.rw = r & v & (w != 5'd0);
      x.m2r = m; x.vld = v; x.adel = xadel;
      x.ret = last.ret + (v ? 4'd1 : 4'd0);
    end else begin
      x = last;
    end
    x.due = cyc + 1;
    last = x;
    q.push_back(x);
  endtask

  // Monitor: compares the DUT against the head of the scoreboard once it is due.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due <= cyc) begin
      mx = q.pop_front();
      chk("ALUOut_W", ALUOut_W, mx.alu);
      chk("DMOut_W", DMOut_W, mx.dm);
      chk("PC4_W", PC4_W, mx.pc4);
      chk("WriteReg_W", 32'(WriteReg_W), 32'(mx.wr));
      chk("RegWrite_W", 32'(RegWrite_W), 32'(mx.rw));
      chk("MemtoReg_W", 32'(MemtoReg_W), 32'(mx.m2r));
      chk("valid_W", 32'(valid_W), 32'(mx.vld));
      chk("AdEL_W", 32'(AdEL_W), 32'(mx.adel));
      chk("retired", 32'(retired), 32'(mx.ret));
    end
  end

  localparam logic [31:0] RDW = 32'h8077_F0A5;
  localparam logic [31:0] PCV = 32'h0040_0004;

  initial begin
    last = '{default: 0};
    reset_n = 1'b0;
    en = 1'b1; clr = 1'b0; valid_M = 1'b1;
    ALUOut_M = 32'hDEAD_BEEF; RD_M = 32'hCAFE_F00D; PC4_M = 32'h1234_5678;
    WriteReg_M = 5'd7; RegWrite_M = 1'b1; MemtoReg_M = 2'b01; LoadType_M = 3'd2;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    en = 1'b0;
    reset_n = 1'b1;

    // Load extension            e    c    v    alu           rd    pc   w     r    m      lt    dm              adel
    issue(1'b1, 1'b0, 1'b1, 32'h1001, RDW, PCV, 5'd3, 1'b1, 2'b01, 3'd2, 32'hFFFF_FFF0, 1'b0); // lb
    issue(1'b1, 1'b0, 1'b1, 32'h1001, RDW, PCV, 5'd3, 1'b1, 2'b01, 3'd1, 32'h0000_00F0, 1'b0); // lbu
    issue(1'b1, 1'b0, 1'b1, 32'h1002, RDW, PCV, 5'd3, 1'b1, 2'b01, 3'd4, 32'hFFFF_8077, 1'b0); // lh
    issue(1'b1, 1'b0, 1'b1, 32'h1002, RDW, PCV, 5'd3, 1'b1, 2'b01, 3'd3, 32'h0000_8077, 1'b0); // lhu
    issue(1'b1, 1'b0, 1'b1, 32'h1000, RDW, PCV, 5'd3, 1'b1, 2'b01, 3'd0, RDW,           1'b0); // lw
    issue(1'b1, 1'b0, 1'b1, 32'h1000, RDW, PCV, 5'd3, 1'b1, 2'b01, 3'd2, 32'hFFFF_FFA5, 1'b0); // lb off0
    issue(1'b1, 1'b0, 1'b1, 32'h1002, RDW, PCV, 5'd3, 1'b1, 2'b01, 3'd2, 32'h0000_0077, 1'b0); // lb off2
    issue(1'b1, 1'b0, 1'b1, 32'h1000, RDW, PCV, 5'd3, 1'b1, 2'b01, 3'd3, 32'h0000_F0A5, 1'b0); // lhu off0
    // Misalignment
    issue(1'b1, 1'b0, 1'b1, 32'h1002, RDW, PCV, 5'd3, 1'b1, 2'b01, 3'd0, RDW,           1'b1); // lw off2
    issue(1'b1, 1'b0, 1'b1, 32'h1003, RDW, PCV, 5'd3, 1'b1, 2'b01, 3'd4, 32'hFFFF_8077, 1'b1); // lh off3
    issue(1'b1, 1'b0, 1'b1, 32'h1003, RDW, PCV, 5'd3, 1'b1, 2'b01, 3'd1, 32'h0000_0080, 1'b0); // lbu off3
    issue(1'b1, 1'b0, 1'b1, 32'h1003, RDW, PCV, 5'd3, 1'b1, 2'b00, 3'd4, 32'hFFFF_8077, 1'b0); // not a load
    issue(1'b1, 1'b0, 1'b0, 32'h1002, RDW, PCV, 5'd3, 1'b1, 2'b01, 3'd0, RDW,           1'b0); // invalid slot
    issue(1'b1, 1'b0, 1'b1, 32'h1002, RDW, PCV, 5'd3, 1'b1, 2'b01, 3'd7, RDW,           1'b1); // unknown -> lw
    issue(1'b1, 1'b0, 1'b1, 32'h1001, RDW, PCV, 5'd3, 1'b1, 2'b01, 3'd3, 32'h0000_F0A5, 1'b1); // lhu off1
    // Stall then flush
    issue(1'b1, 1'b0, 1'b1, 32'h2000, 32'h1234_5678, 32'h0040_0010, 5'd5, 1'b1, 2'b00, 3'd0, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b0, 1'b1, 32'h3000 + 32'(i), 32'hA5A5_0000 + 32'(i), 32'h50 + 32'(i),
            5'(9 + i), 1'b1, 2'b10, 3'd2, 32'h0, 1'b0);
    end
    issue(1'b1, 1'b1, 1'b1, 32'h4003, RDW, PCV, 5'd6, 1'b1, 2'b01, 3'd0, 32'h0, 1'b0);      // bubble
    // $0 suppression
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0044, RDW, PCV, 5'd0, 1'b1, 2'b00, 3'd0, RDW, 1'b0);
    // MemtoReg = 11 passes through; no load flag
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0046, RDW, PCV, 5'd31, 1'b1, 2'b11, 3'd0, RDW, 1'b0);
    // Counter wrap in the 4-bit build: advance to 15, then one more valid latch -> 0
    for (int n = 0; n < 20 && last.ret != 4'hF; n++) begin
      issue(1'b1, 1'b0, 1'b1, 32'h100 + 32'(n), RDW, PCV, 5'd2, 1'b0, 2'b00, 3'd0, RDW, 1'b0);
    end
    issue(1'b1, 1'b0, 1'b1, 32'h0000_0ABC, RDW, PCV, 5'd4, 1'b1, 2'b10, 3'd0, RDW, 1'b0);
    issue(1'b0, 1'b0, 1'b1, 32'h0000_0DEF, RDW, PCV, 5'd8, 1'b1, 2'b01, 3'd0, RDW, 1'b0);  // stall

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end

    // Asynchronous reset mid-stall: outputs clear with no clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("async_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
